// File: rtl/accu_split.sv
// accu_split: takes one DATA_W*BEATS word per handshake and emits it as
// BEATS narrow beats, LSB beat first, each with a valid/ready handshake.
// Holds one word and sustains one beat per cycle, with no bubble between
// back-to-back words (the next word is taken in the cycle the last beat leaves).
//
// Optional feature, enabled by defining ACCU_SPLIT_SUM_EN:
//   sum_out   - running sum of the beats of the current word; holds the full
//               word sum from the cycle after its last beat until the next
//               beat 0 transfers.
//   sum_valid - one-cycle pulse in the cycle after the last beat's transfer.
module accu_split #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 4   // must be >= 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W*BEATS-1:0]         data_in,
    input  logic                            valid_in,
    output logic                            ready_in,
    output logic                            valid_out,
    input  logic                            ready_a,
    output logic [DATA_W-1:0]               data_out,
    output logic                            last_out
`ifdef ACCU_SPLIT_SUM_EN
    ,
    output logic [DATA_W+$clog2(BEATS)-1:0] sum_out,
    output logic                            sum_valid
`endif
);

    localparam int CNT_W  = $clog2(BEATS);
    localparam int WORD_W = DATA_W * BEATS;

    // Index of the final beat of a word.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    // IDLE: no word held. BUSY: a word is held and its beats are being sent.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WORD_W-1:0]  wd;        // word currently being split
    logic [CNT_W-1:0]   cnt;       // index of the beat on data_out
    logic               busy;
    logic               cnt_last;
    logic               acc;       // word accepted this cycle
    logic               xfer;      // beat transferred this cycle

    assign busy     = (state == S_BUSY);
    assign cnt_last = (cnt == LAST_IDX);

    // valid_out is exactly busy, so the beat handshake is formed from busy
    // directly; this keeps ready_in free of any path through its own block.
    assign xfer = busy && ready_a;
    assign acc  = valid_in && ready_in;

    // State register; reset drops valid_out asynchronously and discards any
    // partial word.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a new word moves IDLE to BUSY; the last beat returns to
    // IDLE unless another word is accepted in that same cycle.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (xfer && cnt_last && !acc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: beat select from the held word plus handshake flags.
    // ready_in looks at ready_a so a word can be taken as the last beat leaves.
    always_comb begin
        valid_out = busy;
        last_out  = busy && cnt_last;
        ready_in  = !busy || (ready_a && cnt_last);
        data_out  = wd[cnt*DATA_W +: DATA_W];
    end

    // Word register and beat index: load on accept, advance on each beat
    // transfer, wrap to 0 after the last beat. Both hold under backpressure.
    // NOTE: wd is a plain register, not a memory, and is reset so data_out
    // reads 0 during and after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd  <= '0;
            cnt <= '0;
        end else if (acc) begin
            wd  <= data_in;
            cnt <= '0;
        end else if (xfer) begin
            if (cnt_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef ACCU_SPLIT_SUM_EN
    localparam int SUM_W = DATA_W + CNT_W;

    // Beat sum: beat 0 restarts the sum, later beats add into it; sum_valid
    // pulses in the cycle after the last beat. The width cannot overflow for
    // BEATS beats of DATA_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= xfer && cnt_last;
            if (xfer) begin
                if (cnt == '0) begin
                    sum_out <= SUM_W'(data_out);
                end else begin
                    sum_out <= sum_out + SUM_W'(data_out);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_accu_split.sv
// Testbench for accu_split: directed scenarios with hand-written expected
// beats, then randomized handshakes checked against a queue-based model.
module tb_accu_split;

    localparam int DATA_W = 8;
    localparam int BEATS  = 4;
    localparam int WORD_W = DATA_W * BEATS;
    localparam int SUM_W  = DATA_W + $clog2(BEATS);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WORD_W-1:0]  data_in = '0;
    logic               valid_in = 1'b0;
    logic               ready_a = 1'b0;
    logic               ready_in;
    logic               valid_out;
    logic [DATA_W-1:0]  data_out;
    logic               last_out;
`ifdef ACCU_SPLIT_SUM_EN
    logic [SUM_W-1:0]   sum_out;
    logic               sum_valid;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of beats still owed downstream, and the sum of
    // each queued word.
    logic [DATA_W-1:0]  q[$];
    int                 sq[$];
    bit                 m_sum_pulse = 1'b0;
    int                 m_sum = 0;

    accu_split #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .ready_a   (ready_a),
        .data_out  (data_out),
        .last_out  (last_out)
`ifdef ACCU_SPLIT_SUM_EN
        ,
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // Model: can a word be taken now? Only when nothing is owed, or when the
    // single remaining beat leaves this cycle.
    function automatic bit exp_ready();
        return (q.size() == 0) || (q.size() == 1 && ready_a);
    endfunction

    function automatic void model_clear();
        q.delete();
        sq.delete();
        m_sum_pulse = 1'b0;
        m_sum = 0;
    endfunction

    // Cross one rising edge, advance the model with the inputs in force at
    // that edge, and leave the bench 1 time unit after the edge.
    task automatic tick();
        bit                acc;
        bit                xfer;
        logic [WORD_W-1:0] w;
        int                s;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            acc  = valid_in && exp_ready();
            xfer = (q.size() != 0) && ready_a;
            m_sum_pulse = 1'b0;
            if (xfer) begin
                if (q.size() == 1) begin
                    m_sum_pulse = 1'b1;
                    m_sum = sq.pop_front();
                end
                void'(q.pop_front());
            end
            if (acc) begin
                w = data_in;
                s = 0;
                for (int i = 0; i < BEATS; i++) begin
                    q.push_back(w[i*DATA_W +: DATA_W]);
                    s += int'(w[i*DATA_W +: DATA_W]);
                end
                sq.push_back(s);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b1;
        ready_a = 1'b1;
        data_in = 32'hDEADBEEF;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        n_cmp++; if (last_out !== 1'b0) begin n_err++; $display("FAIL reset_last_out: got %b expected 0", last_out); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
`ifdef ACCU_SPLIT_SUM_EN
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b expected 0", sum_valid); end
        n_cmp++; if (sum_out !== '0) begin n_err++; $display("FAIL reset_sum_out: got %h expected 0", sum_out); end
`endif
        rst = 1'b0;
        tick();  // first word accepted on this edge
        valid_in = 1'b0;
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL reset_first_accept_valid: got %b expected 1", valid_out); end
        n_cmp++; if (data_out !== 8'hEF) begin n_err++; $display("FAIL reset_first_accept_data: got %h expected ef", data_out); end
        repeat (BEATS) tick();
    endtask

    task automatic test_single();
        logic [WORD_W-1:0] w;
        w = 32'h44332211;
        data_in = w;
        valid_in = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL single_idle_ready: got %b expected 1", ready_in); end
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            @(negedge clk);
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b expected 1", i, valid_out); end
            n_cmp++; if (data_out !== w[i*DATA_W +: DATA_W]) begin n_err++; $display("FAIL single_data[%0d]: got %h expected %h", i, data_out, w[i*DATA_W +: DATA_W]); end
            n_cmp++; if (last_out !== (i == BEATS-1)) begin n_err++; $display("FAIL single_last[%0d]: got %b expected %b", i, last_out, (i == BEATS-1)); end
            n_cmp++; if (ready_in !== (i == BEATS-1)) begin n_err++; $display("FAIL single_ready[%0d]: got %b expected %b", i, ready_in, (i == BEATS-1)); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL single_after_valid: got %b expected 0", valid_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        data_in = 32'h04030201;
        valid_in = 1'b1;
        ready_a = 1'b1;
        tick();
        data_in = 32'h08070605;
        for (int k = 0; k < 2*BEATS; k++) begin
            @(negedge clk);
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, valid_out); end
            n_cmp++; if (data_out !== DATA_W'(k + 1)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_out, DATA_W'(k + 1)); end
            n_cmp++; if (ready_in !== (k == 3 || k == 7)) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, ready_in, (k == 3 || k == 7)); end
            n_cmp++; if (last_out !== (k == 3 || k == 7)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b expected %b", k, last_out, (k == 3 || k == 7)); end
            tick();
            if (k == 3) valid_in = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_after_valid: got %b expected 0", valid_out); end
        tick();
    endtask

    task automatic test_backpressure();
        data_in = 32'h44332211;
        valid_in = 1'b1;
        ready_a = 1'b1;
        tick();
        valid_in = 1'b0;
        data_in = 32'hA5A5A5A5;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL bp_beat0: got %h expected 11", data_out); end
        tick();
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (data_out !== 8'h22) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h expected 22", i, data_out); end
            n_cmp++; if (last_out !== 1'b0) begin n_err++; $display("FAIL bp_hold_last[%0d]: got %b expected 0", i, last_out); end
            n_cmp++; if (ready_in !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, ready_in); end
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, valid_out); end
            tick();
        end
        ready_a = 1'b1;
        for (int i = 1; i < BEATS; i++) begin
            @(negedge clk);
            n_cmp++; if (data_out !== DATA_W'(8'h11 * (i + 1))) begin n_err++; $display("FAIL bp_resume[%0d]: got %h expected %h", i, data_out, DATA_W'(8'h11 * (i + 1))); end
            n_cmp++; if (last_out !== (i == BEATS-1)) begin n_err++; $display("FAIL bp_resume_last[%0d]: got %b expected %b", i, last_out, (i == BEATS-1)); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bp_after_valid: got %b expected 0", valid_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        data_in = 32'h44332211;
        valid_in = 1'b1;
        ready_a = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();  // 0x11 transfers
        tick();  // 0x22 transfers
        n_cmp++; if (data_out !== 8'h33) begin n_err++; $display("FAIL rmid_pre_data: got %h expected 33", data_out); end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_async_valid: got %b expected 0", valid_out); end
        n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL rmid_async_ready: got %b expected 1", ready_in); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_no_resume_valid[%0d]: got %b expected 0 (data %h)", i, valid_out, data_out); end
            n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL rmid_ready[%0d]: got %b expected 1", i, ready_in); end
        end
        tick();
    endtask

`ifdef ACCU_SPLIT_SUM_EN
    task automatic test_sum();
        data_in = 32'hFFFFFFFF;
        valid_in = 1'b1;
        ready_a = 1'b1;
        tick();
        data_in = 32'h04030201;
        for (int k = 0; k < 2*BEATS; k++) begin
            @(negedge clk);
            n_cmp++; if (sum_valid !== (k == 4)) begin n_err++; $display("FAIL sum_pulse[%0d]: got %b expected %b", k, sum_valid, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (sum_out !== 10'h3FC) begin n_err++; $display("FAIL sum_word1: got %h expected 3fc", sum_out); end
            end
            tick();
            if (k == 3) valid_in = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL sum_pulse_word2: got %b expected 1", sum_valid); end
        n_cmp++; if (sum_out !== 10'h00A) begin n_err++; $display("FAIL sum_word2: got %h expected 00a", sum_out); end
        tick();
        @(negedge clk);
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL sum_pulse_end: got %b expected 0", sum_valid); end
        n_cmp++; if (sum_out !== 10'h00A) begin n_err++; $display("FAIL sum_hold: got %h expected 00a", sum_out); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_a  = ($urandom_range(0, 3) != 0);
            data_in  = $urandom;
            @(negedge clk);
            n_cmp++; if (valid_out !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, valid_out, (q.size() != 0)); end
            n_cmp++; if (ready_in !== exp_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, ready_in, exp_ready()); end
            n_cmp++; if (last_out !== (q.size() == 1)) begin n_err++; $display("FAIL rnd_last[%0d]: got %b expected %b", c, last_out, (q.size() == 1)); end
            if (q.size() != 0) begin
                n_cmp++; if (data_out !== q[0]) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, data_out, q[0]); end
            end
`ifdef ACCU_SPLIT_SUM_EN
            n_cmp++; if (sum_valid !== m_sum_pulse) begin n_err++; $display("FAIL rnd_sum_valid[%0d]: got %b expected %b", c, sum_valid, m_sum_pulse); end
            if (m_sum_pulse) begin
                n_cmp++; if (sum_out !== SUM_W'(m_sum)) begin n_err++; $display("FAIL rnd_sum[%0d]: got %h expected %h", c, sum_out, SUM_W'(m_sum)); end
            end
`endif
            tick();
        end
        valid_in = 1'b0;
        ready_a = 1'b1;
        repeat (BEATS + 1) tick();
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rnd_drain_valid: got %b expected 0", valid_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef ACCU_SPLIT_SUM_EN
        test_sum();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
